// File: rtl/snn_pkg.sv
// Shared types and helpers for the LIF spiking-neuron layer.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic RESET_SUB  = 1'b0;
  localparam logic RESET_ZERO = 1'b1;

  // Unsigned add clamped to 2^w-1; operands and w are limited to 32 bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] max_val;
    sum     = {1'b0, a} + {1'b0, b};
    max_val = (33'd1 << w) - 33'd1;
    return (sum > max_val) ? max_val[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/snn_lif_neuron.sv
// Combinational leaky integrate-and-fire update for one neuron; shared
// across the layer by time-multiplexing.
module snn_lif_neuron
  import snn_pkg::*;
#(
  parameter int unsigned IN_W    = 8,
  parameter int unsigned STATE_W = 12,
  parameter int unsigned SHIFT_W = 4
) (
  input  logic [STATE_W-1:0] mem,
  input  logic [IN_W-1:0]    in_i,
  input  logic [STATE_W-1:0] thresh,
  input  logic [SHIFT_W-1:0] leak_shift,
  input  logic               reset_mode,
  input  logic               refrac_active,
  output logic [STATE_W-1:0] mem_next,
  output logic               fire
);

  logic [STATE_W-1:0] leak;
  logic [STATE_W-1:0] base;
  logic [STATE_W-1:0] sum;
  logic [IN_W-1:0]    in_eff;

  always_comb begin
    leak     = (leak_shift == '0) ? '0 : (mem >> leak_shift);
    // leak never exceeds mem, so this difference cannot wrap
    base     = mem - leak;
    in_eff   = refrac_active ? '0 : in_i;
    sum      = STATE_W'(sat_add(32'(base), 32'(in_eff), STATE_W));
    fire     = !refrac_active && (sum >= thresh);
    mem_next = sum;
    if (fire) begin
      mem_next = (reset_mode == RESET_ZERO) ? '0 : (sum - thresh);
    end
  end

endmodule

// File: rtl/snn_lif_layer.sv
// Time-multiplexed LIF neuron layer: one neuron updated per cycle per step.
// Define SNN_REFRACTORY_EN to add per-neuron refractory counters.
module snn_lif_layer
  import snn_pkg::*;
#(
  parameter  int unsigned NUM_NEURONS = 4,
  parameter  int unsigned IN_W        = 8,
  parameter  int unsigned STATE_W     = 12,
  parameter  int unsigned SHIFT_W     = 4,
  parameter  int unsigned REFRAC_W    = 4,
  localparam int unsigned SEL_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        step_valid,
  output logic                        step_ready,
  input  logic [NUM_NEURONS*IN_W-1:0] in_cur,
  input  logic [STATE_W-1:0]          thresh,
  input  logic [SHIFT_W-1:0]          leak_shift,
  input  logic                        reset_mode,
  input  logic                        clear,
`ifdef SNN_REFRACTORY_EN
  input  logic [REFRAC_W-1:0]         refrac_steps,
`endif
  output logic [NUM_NEURONS-1:0]      spike_out,
  output logic                        out_valid,
  input  logic [SEL_W-1:0]            state_sel,
  output logic [STATE_W-1:0]          state_out
);

  if (NUM_NEURONS < 1 || STATE_W < IN_W + 1 || STATE_W > 32 || REFRAC_W < 1) begin : g_bad_params
    $error("snn_lif_layer: illegal parameter combination");
  end

  state_e                      state_q, state_d;
  logic [SEL_W-1:0]            idx_q, idx_d;
  logic [NUM_NEURONS*IN_W-1:0] cur_q, cur_d;
  logic [STATE_W-1:0]          thresh_q, thresh_d;
  logic [SHIFT_W-1:0]          shift_q, shift_d;
  logic                        mode_q, mode_d;
  logic [STATE_W-1:0]          mem_q [NUM_NEURONS];
  logic [STATE_W-1:0]          mem_d [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]      shadow_q, shadow_d;
  logic [NUM_NEURONS-1:0]      spike_q, spike_d;
  logic                        valid_q, valid_d;
  logic                        ready_q, ready_d;
  logic [STATE_W-1:0]          sout_q, sout_d;

  logic                        accept;
  logic [IN_W-1:0]             in_sel;
  logic [STATE_W-1:0]          mem_upd;
  logic                        fire;
  logic                        refrac_active;

  // ready_q tracks "FSM is idle"; clear vetoes acceptance in the same cycle
  assign step_ready = ready_q && !clear;
  assign accept     = step_valid && step_ready;
  assign in_sel     = cur_q[IN_W*32'(idx_q) +: IN_W];

  assign spike_out  = spike_q;
  assign out_valid  = valid_q;
  assign state_out  = sout_q;

  snn_lif_neuron #(
    .IN_W    (IN_W),
    .STATE_W (STATE_W),
    .SHIFT_W (SHIFT_W)
  ) u_neuron (
    .mem           (mem_q[idx_q]),
    .in_i          (in_sel),
    .thresh        (thresh_q),
    .leak_shift    (shift_q),
    .reset_mode    (mode_q),
    .refrac_active (refrac_active),
    .mem_next      (mem_upd),
    .fire          (fire)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cur_d    = cur_q;
    thresh_d = thresh_q;
    shift_d  = shift_q;
    mode_d   = mode_q;
    mem_d    = mem_q;
    shadow_d = shadow_q;
    spike_d  = spike_q;
    valid_d  = 1'b0;
    sout_d   = (32'(state_sel) < NUM_NEURONS) ? mem_q[state_sel] : '0;

    case (state_q)
      IDLE: begin
        if (clear) begin
          for (int i = 0; i < NUM_NEURONS; i++) mem_d[i] = '0;
        end else if (accept) begin
          cur_d    = in_cur;
          thresh_d = thresh;
          shift_d  = leak_shift;
          mode_d   = reset_mode;
          idx_d    = '0;
          state_d  = UPDATE;
        end
      end
      UPDATE: begin
        mem_d[idx_q]    = mem_upd;
        shadow_d[idx_q] = fire;
        if (idx_q == SEL_W'(NUM_NEURONS - 1)) state_d = DONE;
        else                                   idx_d   = idx_q + SEL_W'(1);
      end
      DONE: begin
        spike_d = shadow_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cur_q    <= '0;
      thresh_q <= '0;
      shift_q  <= '0;
      mode_q   <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) mem_q[i] <= '0;
      shadow_q <= '0;
      spike_q  <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
      sout_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cur_q    <= cur_d;
      thresh_q <= thresh_d;
      shift_q  <= shift_d;
      mode_q   <= mode_d;
      mem_q    <= mem_d;
      shadow_q <= shadow_d;
      spike_q  <= spike_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      sout_q   <= sout_d;
    end
  end

`ifdef SNN_REFRACTORY_EN
  logic [REFRAC_W-1:0] rcnt_q [NUM_NEURONS];
  logic [REFRAC_W-1:0] rcnt_d [NUM_NEURONS];
  logic [REFRAC_W-1:0] rsteps_q, rsteps_d;

  assign refrac_active = (rcnt_q[idx_q] != '0);

  // Refractory counters: reload on fire, count down while blocking input
  always_comb begin
    rcnt_d   = rcnt_q;
    rsteps_d = rsteps_q;
    if (state_q == IDLE) begin
      if (clear) begin
        for (int i = 0; i < NUM_NEURONS; i++) rcnt_d[i] = '0;
      end else if (accept) begin
        rsteps_d = refrac_steps;
      end
    end else if (state_q == UPDATE) begin
      if (refrac_active) rcnt_d[idx_q] = rcnt_q[idx_q] - REFRAC_W'(1);
      else if (fire)     rcnt_d[idx_q] = rsteps_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) rcnt_q[i] <= '0;
      rsteps_q <= '0;
    end else begin
      rcnt_q   <= rcnt_d;
      rsteps_q <= rsteps_d;
    end
  end
`else
  assign refrac_active = 1'b0;
`endif

endmodule
